// File: rtl/multicycle_control.sv
// Multicycle RISC-V controller: Moore FSM sequencing fetch, decode and the
// per-class execute/writeback steps, with combinational datapath controls.
// Ports:
//   CLK, RST          clock and synchronous active-high reset
//   op, funct3,       instruction fields Instr[6:0], Instr[14:12], Instr[30]
//   funct7_5
//   Zero              ALU zero flag
//   PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
//   ALUControl, ImmSrc, RegWrite   datapath controls
//   Retire            pulse in the last cycle of every instruction
//   State             current state encoding
module multicycle_control #(
  parameter int unsigned OP_WIDTH       = 7,
  parameter int unsigned FUNCT3_WIDTH   = 3,
  parameter int unsigned ALU_CTRL_WIDTH = 3,
  parameter int unsigned IMM_SRC_WIDTH  = 2
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [OP_WIDTH-1:0]       op,
  input  logic [FUNCT3_WIDTH-1:0]   funct3,
  input  logic                      funct7_5,
  input  logic                      Zero,
  output logic                      PCWrite,
  output logic                      AdrSrc,
  output logic                      MemWrite,
  output logic                      IRWrite,
  output logic [1:0]                ResultSrc,
  output logic [1:0]                ALUSrcA,
  output logic [1:0]                ALUSrcB,
  output logic [ALU_CTRL_WIDTH-1:0] ALUControl,
  output logic [IMM_SRC_WIDTH-1:0]  ImmSrc,
  output logic                      RegWrite,
  output logic                      Retire,
  output logic [3:0]                State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_SUB   = 2'd1,
    ALU_FUNCT = 2'd2
  } alu_op_t;

  localparam logic [OP_WIDTH-1:0] OP_LOAD   = OP_WIDTH'(7'b0000011);
  localparam logic [OP_WIDTH-1:0] OP_STORE  = OP_WIDTH'(7'b0100011);
  localparam logic [OP_WIDTH-1:0] OP_RTYPE  = OP_WIDTH'(7'b0110011);
  localparam logic [OP_WIDTH-1:0] OP_ITYPE  = OP_WIDTH'(7'b0010011);
  localparam logic [OP_WIDTH-1:0] OP_BRANCH = OP_WIDTH'(7'b1100011);
  localparam logic [OP_WIDTH-1:0] OP_JAL    = OP_WIDTH'(7'b1101111);

  state_t  state;
  state_t  state_next;
  alu_op_t alu_op;
  logic    op_supported;

  assign State = state;

  assign op_supported = (op == OP_LOAD) || (op == OP_STORE) || (op == OP_RTYPE) ||
                        (op == OP_ITYPE) || (op == OP_BRANCH) || (op == OP_JAL);

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state <= S_FETCH;
    else     state <= state_next;
  end

  // Next-state logic; illegal encodings fall back to FETCH
  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:    state_next = S_DECODE;
      S_DECODE: begin
        if ((op == OP_LOAD) || (op == OP_STORE)) state_next = S_MEMADR;
        else if (op == OP_RTYPE)                 state_next = S_EXECR;
        else if (op == OP_ITYPE)                 state_next = S_EXECI;
        else if (op == OP_BRANCH)                state_next = S_BRANCH;
        else if (op == OP_JAL)                   state_next = S_JAL;
        else                                     state_next = S_FETCH;
      end
      S_MEMADR:   state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_next = S_MEMWB;
      S_EXECR,
      S_EXECI,
      S_JAL:      state_next = S_ALUWB;
      default:    state_next = S_FETCH;
    endcase
  end

  // Per-state datapath controls; write enables are squashed during reset
  always_comb begin
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    alu_op    = ALU_ADD;
    RegWrite  = 1'b0;
    Retire    = 1'b0;
    case (state)
      S_FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        Retire  = ~op_supported;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        Retire    = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        Retire   = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        alu_op  = ALU_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = ALU_FUNCT;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        Retire   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        alu_op  = ALU_SUB;
        // funct3[0] inverts the sense so bne shares the beq path
        PCWrite = Zero ^ funct3[0];
        Retire  = 1'b1;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      default: ;
    endcase
    if (RST) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      Retire   = 1'b0;
    end
  end

  // ALU decoder; sub only for R-type (op[5]) so addi ignores Instr[30]
  always_comb begin
    ALUControl = ALU_CTRL_WIDTH'(3'b000);
    case (alu_op)
      ALU_SUB: ALUControl = ALU_CTRL_WIDTH'(3'b001);
      ALU_FUNCT: begin
        case (funct3)
          FUNCT3_WIDTH'(3'b000):
            ALUControl = (op[5] && funct7_5) ? ALU_CTRL_WIDTH'(3'b001) : ALU_CTRL_WIDTH'(3'b000);
          FUNCT3_WIDTH'(3'b010): ALUControl = ALU_CTRL_WIDTH'(3'b101);
          FUNCT3_WIDTH'(3'b110): ALUControl = ALU_CTRL_WIDTH'(3'b011);
          FUNCT3_WIDTH'(3'b111): ALUControl = ALU_CTRL_WIDTH'(3'b010);
          default:               ALUControl = ALU_CTRL_WIDTH'(3'b000);
        endcase
      end
      default: ALUControl = ALU_CTRL_WIDTH'(3'b000);
    endcase
  end

  // Immediate format follows the opcode in every state
  always_comb begin
    ImmSrc = IMM_SRC_WIDTH'(2'b00);
    if (op == OP_STORE)       ImmSrc = IMM_SRC_WIDTH'(2'b01);
    else if (op == OP_BRANCH) ImmSrc = IMM_SRC_WIDTH'(2'b10);
    else if (op == OP_JAL)    ImmSrc = IMM_SRC_WIDTH'(2'b11);
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: an instruction-level model supplies the
// state walk for each instruction class and the control word per step.
module tb_multicycle_control;

  logic       CLK = 1'b0;
  logic       RST;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Retire;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] State;

  always #5 CLK = ~CLK;

  multicycle_control dut (
    .CLK(CLK), .RST(RST), .op(op), .funct3(funct3), .funct7_5(funct7_5), .Zero(Zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ImmSrc(ImmSrc), .RegWrite(RegWrite), .Retire(Retire), .State(State)
  );

  int checks = 0;
  int errors = 0;

  logic [20:0] act_vec;
  logic [20:0] exp_vec;
  logic        chk_en = 1'b0;
  logic [31:0] trace;
  int          n_retire, n_regw, n_memw;
  logic        br_pcw;
  logic [2:0]  exec_alu;

  assign act_vec = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                    ALUControl, ImmSrc, RegWrite, Retire, State};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111;

  function automatic logic supported(input logic [6:0] o);
    return (o == LW) || (o == SW) || (o == RT) || (o == IT) || (o == BR) || (o == JL);
  endfunction

  // State walk per instruction class, nibble-packed oldest first
  function automatic void model_seq(input logic [6:0] o, output logic [31:0] seq, output int len);
    case (o)
      LW:      begin seq = 32'h01234; len = 5; end
      SW:      begin seq = 32'h0125;  len = 4; end
      RT:      begin seq = 32'h0168;  len = 4; end
      IT:      begin seq = 32'h0178;  len = 4; end
      BR:      begin seq = 32'h019;   len = 3; end
      JL:      begin seq = 32'h01A8;  len = 4; end
      default: begin seq = 32'h01;    len = 2; end
    endcase
  endfunction

  // Control word for one step of an instruction
  function automatic logic [20:0] model_out(input int st, input logic [6:0] o, input logic [2:0] f3,
                                            input logic f7, input logic z, input logic rst);
    logic pcw, adr, mw, irw, rw, ret;
    logic [1:0] rs, sa, sb, imm;
    logic [2:0] alu, fn;
    {pcw, adr, mw, irw, rw, ret} = 6'b0;
    rs = 2'b00; sa = 2'b00; sb = 2'b00; alu = 3'b000;
    case (f3)
      3'b000:  fn = (o[5] && f7) ? 3'b001 : 3'b000;
      3'b010:  fn = 3'b101;
      3'b110:  fn = 3'b011;
      3'b111:  fn = 3'b010;
      default: fn = 3'b000;
    endcase
    imm = (o == SW) ? 2'b01 : (o == BR) ? 2'b10 : (o == JL) ? 2'b11 : 2'b00;
    case (st)
      0:  begin irw = 1; sb = 2'b10; rs = 2'b10; pcw = 1; end
      1:  begin sa = 2'b01; sb = 2'b01; ret = !supported(o); end
      2:  begin sa = 2'b10; sb = 2'b01; end
      3:  adr = 1;
      4:  begin rs = 2'b01; rw = 1; ret = 1; end
      5:  begin adr = 1; mw = 1; ret = 1; end
      6:  begin sa = 2'b10; alu = fn; end
      7:  begin sa = 2'b10; sb = 2'b01; alu = fn; end
      8:  begin rw = 1; ret = 1; end
      9:  begin sa = 2'b10; alu = 3'b001; pcw = z ^ f3[0]; ret = 1; end
      10: begin sa = 2'b01; sb = 2'b10; pcw = 1; end
      default: ;
    endcase
    if (rst) {pcw, mw, irw, rw, ret} = 5'b0;
    return {pcw, adr, mw, irw, rs, sa, sb, alu, imm, rw, ret, 4'(st)};
  endfunction

  // Compare process: full control word every checked cycle, plus trace capture
  always @(negedge CLK) begin
    if (chk_en) begin
      check("ctrl_word", {11'b0, act_vec}, {11'b0, exp_vec});
      trace    = {trace[27:0], State};
      n_retire = n_retire + int'(Retire);
      n_regw   = n_regw + int'(RegWrite);
      n_memw   = n_memw + int'(MemWrite);
      if (State == 4'd9) br_pcw = PCWrite;
      if (State == 4'd6 || State == 4'd7) exec_alu = ALUControl;
    end
  end

  // Runs one instruction starting at posedge+1 in FETCH; zmode<0 randomizes Zero;
  // abort_at>=0 raises RST in that step and holds it one more cycle.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input int zmode, input int abort_at);
    logic [31:0] seq;
    int len, st;
    model_seq(o, seq, len);
    trace = 32'h0; n_retire = 0; n_regw = 0; n_memw = 0; br_pcw = 1'bx; exec_alu = 3'bx;
    for (int k = 0; k < len; k++) begin
      op = o; funct3 = f3; funct7_5 = f7;
      Zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      st = int'((seq >> (4 * (len - 1 - k))) & 32'hF);
      RST = (k == abort_at);
      exp_vec = model_out(st, o, f3, f7, Zero, RST);
      chk_en = 1'b1;
      @(posedge CLK); #1;
      if (k == abort_at) begin
        exp_vec = model_out(0, o, f3, f7, Zero, 1'b1);
        @(posedge CLK); #1;
        RST = 1'b0;
        return;
      end
    end
  endtask

  initial begin
    logic [6:0] o;
    int pick;
    RST = 1'b1; op = 7'b0; funct3 = 3'b0; funct7_5 = 1'b0; Zero = 1'b0;
    @(posedge CLK); #1;
    exp_vec = model_out(0, 7'b0, 3'b0, 1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    @(negedge CLK);
    check("reset_state", {28'b0, State}, 32'h0);
    check("reset_we", {27'b0, PCWrite, IRWrite, RegWrite, MemWrite, Retire}, 32'h0);
    @(posedge CLK); #1;
    RST = 1'b0;

    run_instr(LW, 3'b010, 1'b0, -1, -1);
    check("lw_trace", trace, 32'h01234);
    check("lw_regwrite", n_regw, 1);
    check("lw_retire", n_retire, 1);

    run_instr(SW, 3'b010, 1'b0, -1, -1);
    check("sw_trace", trace, 32'h0125);
    check("sw_memwrite", n_memw, 1);
    check("sw_regwrite", n_regw, 0);

    run_instr(RT, 3'b000, 1'b1, -1, -1);
    check("sub_alu", exec_alu, 3'b001);
    run_instr(IT, 3'b000, 1'b1, -1, -1);
    check("addi_alu", exec_alu, 3'b000);
    run_instr(RT, 3'b111, 1'b0, -1, -1);
    check("and_alu", exec_alu, 3'b010);
    run_instr(RT, 3'b010, 1'b0, -1, -1);
    check("slt_alu", exec_alu, 3'b101);

    run_instr(BR, 3'b000, 1'b0, 1, -1);
    check("beq_taken_trace", trace, 32'h019);
    check("beq_taken_pcw", br_pcw, 1);
    run_instr(BR, 3'b000, 1'b0, 0, -1);
    check("beq_nottaken_pcw", br_pcw, 0);
    run_instr(BR, 3'b001, 1'b0, 0, -1);
    check("bne_taken_pcw", br_pcw, 1);

    run_instr(JL, 3'b000, 1'b0, -1, -1);
    check("jal_trace", trace, 32'h01A8);
    check("jal_regwrite", n_regw, 1);

    run_instr(7'b0000000, 3'b000, 1'b0, -1, -1);
    check("nop_trace", trace, 32'h01);
    check("nop_retire", n_retire, 1);
    check("nop_writes", n_regw + n_memw, 0);

    run_instr(SW, 3'b010, 1'b0, -1, 3);
    check("abort_trace", trace, 32'h01250);
    check("abort_memwrite", n_memw, 0);
    run_instr(JL, 3'b000, 1'b0, -1, -1);
    check("resume_trace", trace, 32'h01A8);

    for (int i = 0; i < 300; i++) begin
      pick = int'($urandom_range(0, 6));
      case (pick)
        0: o = LW; 1: o = SW; 2: o = RT; 3: o = IT; 4: o = BR; 5: o = JL;
        default: begin
          o = 7'($urandom);
          while (supported(o)) o = 7'($urandom);
        end
      endcase
      run_instr(o, 3'($urandom), 1'($urandom),
                -1, ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 1)) : -1);
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The module SHALL have these parameters (name, default, meaning):
- OP_WIDTH, 7, opcode width
- FUNCT3_WIDTH, 3, funct3 width
- ALU_CTRL_WIDTH, 3, ALU control width
- IMM_SRC_WIDTH, 2, immediate-select width
REQ-002 The module SHALL have these ports (name, direction, width, meaning):
- CLK, in, 1, the single clock
- RST, in, 1, synchronous active-high reset
- op, in, OP_WIDTH, Instr[6:0] from the instruction register
- funct3, in, FUNCT3_WIDTH, Instr[14:12]
- funct7_5, in, 1, Instr[30]
- Zero, in, 1, ALU zero flag
- PCWrite, out, 1, PC register load enable
- AdrSrc, out, 1, memory address select: 0 = PC, 1 = Result
- MemWrite, out, 1, data store enable
- IRWrite, out, 1, instruction register and OldPC load enable
- ResultSrc, out, 2, 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA, out, 2, 00 = PC, 01 = OldPC, 10 = A register
- ALUSrcB, out, 2, 00 = B register, 01 = ImmExt, 10 = constant 4
- ALUControl, out, ALU_CTRL_WIDTH, 000 add, 001 sub, 010 and, 011 or, 101 slt
- ImmSrc, out, IMM_SRC_WIDTH, 00 I, 01 S, 10 B, 11 J
- RegWrite, out, 1, register file write enable (drives WE3)
- Retire, out, 1, one-cycle pulse in the final cycle of each instruction
- State, out, 4, current FSM state encoding, for observability

Function
REQ-003 The block SHALL be a Moore FSM with a registered 4-bit state. All outputs SHALL be combinational from the state, op, funct3, funct7_5 and Zero.
REQ-004 State encodings SHALL be: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10. Encodings 11–15 are illegal.
REQ-005 Transitions:
- FETCH -> DECODE
- DECODE -> MEMADR (op 0000011 or 0100011), EXECR (0110011), EXECI (0010011), BRANCH (1100011), JAL (1101111)
- DECODE -> FETCH for any other op (executed as a NOP, Retire=1)
- MEMADR -> MEMREAD (op[5]=0) or MEMWRITE (op[5]=1)
- MEMREAD -> MEMWB
- EXECR, EXECI, JAL -> ALUWB
- MEMWB, MEMWRITE, ALUWB, BRANCH -> FETCH
- Any illegal encoding -> FETCH
REQ-006 Per-state outputs SHALL be as follows; any signal not listed is 0 or 00:
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=add, ResultSrc=10, PCWrite=1
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=add (branch target to ALUOut)
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=add
- MEMREAD: ResultSrc=00, AdrSrc=1
- MEMWB: ResultSrc=01, RegWrite=1
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=funct
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=funct
- ALUWB: ResultSrc=00, RegWrite=1
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=sub, ResultSrc=00
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=add, ResultSrc=00, PCWrite=1
REQ-007 In BRANCH, PCWrite SHALL equal Zero XOR funct3[0], so beq (000) and bne (001) are both supported.
REQ-008 The ALUOp=funct decode SHALL be:
- funct3 000: sub when op[5]=1 and funct7_5=1, otherwise add
- funct3 010: slt
- funct3 110: or
- funct3 111: and
- any other funct3: add
REQ-009 ImmSrc SHALL be decoded from op in every state:
- 0100011 -> 01
- 1100011 -> 10
- 1101111 -> 11
- all other ops -> 00
REQ-010 Retire SHALL be 1 in MEMWB, MEMWRITE, ALUWB and BRANCH, and in DECODE when the op is unsupported. It SHALL be 0 otherwise.
REQ-011 Instruction latency in cycles, FETCH through last state inclusive, SHALL be: lw 5, sw 4, R-type 4, I-type ALU 4, branch 3, jal 4, unsupported 2.

Reset
REQ-012 On a rising CLK edge with RST=1, the state SHALL load FETCH (0).
REQ-013 While RST=1, PCWrite, IRWrite, RegWrite, MemWrite and Retire SHALL be forced to 0 regardless of state.
REQ-014 RST asserted mid-instruction (any state) SHALL abandon the instruction. No write enable SHALL be asserted in that cycle or the next, and FETCH SHALL begin on the first edge after RST is deasserted.

Verification
REQ-015 Reset, then lw (op 0000011) -> State sequence 0,1,2,3,4,0; RegWrite=1 only in state 4 with ResultSrc=01; Retire pulses once.
REQ-016 sw (op 0100011) -> State sequence 0,1,2,5,0; MemWrite=1 and AdrSrc=1 only in state 5; ImmSrc=01 throughout; RegWrite never 1.
REQ-017 R-type sub (funct3 000, funct7_5=1) -> ALUControl=001 in EXECR. Same inputs on op 0010011 (addi) -> ALUControl=000 in EXECI. funct3 111 -> 010; funct3 010 -> 101.
REQ-018 Branch (op 1100011) -> State 0,1,9,0 with PCWrite in state 9:
- funct3 000, Zero=1: PCWrite=1
- funct3 000, Zero=0: PCWrite=0
- funct3 001, Zero=0: PCWrite=1
REQ-019 jal (op 1101111) -> State 0,1,10,8,0; PCWrite=1 in state 10; RegWrite=1 in state 8; ImmSrc=11. Unsupported op 0000000 -> State 0,1,0 with Retire=1 in state 1 and no write enable asserted.
REQ-020 RST=1 applied in MEMWRITE -> MemWrite=0 in that cycle, State=0 on the next edge; after RST is deasserted the sequence resumes with FETCH (IRWrite=1).
